// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Load/store size codes and arbiter FSM encoding.
package mem_arb_pkg;

   localparam logic [2:0] LSHB_W  = 3'b000;
   localparam logic [2:0] LSHB_H  = 3'b001;
   localparam logic [2:0] LSHB_HU = 3'b010;
   localparam logic [2:0] LSHB_B  = 3'b011;
   localparam logic [2:0] LSHB_BU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IBUSY = 2'd1,
      ST_DBUSY = 2'd2
   } arb_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads,
// and misalignment detection. Unknown size codes act as WORD.
module lsu_align
   import mem_arb_pkg::*;
(
   input  logic [2:0]  lshb,
   input  logic [1:0]  off,
   input  logic        wr,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_al,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [15:0] half_v;
   logic [7:0]  byte_v;

   // Decode size code into lanes, extension and alignment check
   always_comb begin
      half_v    = off[1] ? rdata[31:16] : rdata[15:0];
      byte_v    = rdata[{off, 3'b000} +: 8];
      be        = 4'b1111;
      wdata_al  = wdata;
      rdata_ext = rdata;
      misalign  = 1'b0;
      unique case (lshb)
         LSHB_H, LSHB_HU: begin
            misalign = off[0];
            if (wr) begin
               be       = off[1] ? 4'b1100 : 4'b0011;
               wdata_al = {2{wdata[15:0]}};
            end
            if (lshb == LSHB_H)
               rdata_ext = {{16{half_v[15]}}, half_v};
            else
               rdata_ext = {16'h0000, half_v};
         end
         LSHB_B, LSHB_BU: begin
            if (wr) begin
               be       = 4'b0001 << off;
               wdata_al = {4{wdata[7:0]}};
            end
            if (lshb == LSHB_B)
               rdata_ext = {{24{byte_v[7]}}, byte_v};
            else
               rdata_ext = {24'h000000, byte_v};
         end
         default: begin
            misalign = |off;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory bus between fetch and data access,
// data first, with stall generation and fetch-kill handling.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          i_kill,
   output logic [DW-1:0] i_rdata,
   output logic          i_valid,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [2:0]    d_lshb,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          d_err,
   output logic          stallF,
   output logic          stallM,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   arb_state_e    state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_wr_q, mem_wr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic          i_valid_q, i_valid_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          d_valid_q, d_valid_d;
   logic          d_err_q, d_err_d;
   logic          kill_pend_q, kill_pend_d;

   logic          idle, gnt_d, gnt_i, ack_i, ack_d;
   logic [3:0]    al_be;
   logic [DW-1:0] al_wdata, al_rdata;
   logic          al_mis;

   lsu_align u_align (
      .lshb      (d_lshb),
      .off       (d_addr[1:0]),
      .wr        (d_wr),
      .wdata     (d_wdata),
      .rdata     (mem_rdata),
      .be        (al_be),
      .wdata_al  (al_wdata),
      .rdata_ext (al_rdata),
      .misalign  (al_mis)
   );

   // A requester whose valid is high this cycle is not re-granted
   assign idle  = (state_q == ST_IDLE);
   assign gnt_d = idle & d_req & ~d_valid_q;
   assign gnt_i = idle & ~gnt_d & i_req & ~i_valid_q & ~i_kill;
   assign ack_i = (state_q == ST_IBUSY) & mem_ack;
   assign ack_d = (state_q == ST_DBUSY) & mem_ack;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         i_valid_q   <= 1'b0;
         d_rdata_q   <= '0;
         d_valid_q   <= 1'b0;
         d_err_q     <= 1'b0;
         kill_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         i_valid_q   <= i_valid_d;
         d_rdata_q   <= d_rdata_d;
         d_valid_q   <= d_valid_d;
         d_err_q     <= d_err_d;
         kill_pend_q <= kill_pend_d;
      end
   end

   // Next-state: misaligned data grants never leave IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_d && !al_mis)
               state_d = ST_DBUSY;
            else if (gnt_i)
               state_d = ST_IBUSY;
         end
         ST_IBUSY, ST_DBUSY: begin
            if (mem_ack)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus launch on grant, result capture and valid pulses on ack
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      i_valid_d   = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_valid_d   = 1'b0;
      d_err_d     = 1'b0;
      kill_pend_d = kill_pend_q;
      if (gnt_d) begin
         if (al_mis) begin
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
         end else begin
            mem_req_d   = 1'b1;
            mem_wr_d    = d_wr;
            mem_addr_d  = d_addr & ~AW'(3);
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
         end
      end else if (gnt_i) begin
         mem_req_d   = 1'b1;
         mem_wr_d    = 1'b0;
         mem_addr_d  = i_addr & ~AW'(3);
         mem_be_d    = 4'b1111;
         mem_wdata_d = '0;
      end
      if (ack_i) begin
         mem_req_d   = 1'b0;
         kill_pend_d = 1'b0;
         if (!(kill_pend_q || i_kill)) begin
            i_valid_d = 1'b1;
            i_rdata_d = mem_rdata;
         end
      end else if (state_q == ST_IBUSY && i_kill) begin
         kill_pend_d = 1'b1;
      end
      if (ack_d) begin
         mem_req_d = 1'b0;
         d_valid_d = 1'b1;
         d_rdata_d = mem_wr_q ? '0 : al_rdata;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_valid   = i_valid_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign d_err     = d_err_q;
   assign stallF    = i_req & ~i_valid_q;
   assign stallM    = d_req & ~d_valid_q;

endmodule
